phase_accumulator: RTL and testbench

- Numerically controlled oscillator (NCO) phase core for the synth voice path.
- Each clock edge adds a tuning word `phase_step` to a free-running, wrapping phase register.
- Also derives wavetable addressing outputs: a full-wave address plus quarter-wave sine address, quadrant and negate flags.
- Sits between the pitch/tuning logic and the waveform lookup and oscillator stages.

---
 rtl/phase_accumulator_pkg.sv | 17 +
 rtl/phase_to_sine_addr.sv | 32 +++
 rtl/phase_accumulator.sv | 55 +++++
 tb/tb_phase_accumulator.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/phase_accumulator_pkg.sv
// Shared synth-voice phase definitions: default widths, phase word type and
// the helper that sizes the sine-address decode slice.
package phase_accumulator_pkg;

    localparam int PHASE_W_DEFAULT     = 32;
    localparam int LUT_ADDR_W_DEFAULT  = 10;
    localparam int QLUT_ADDR_W_DEFAULT = 8;

    typedef logic [PHASE_W_DEFAULT-1:0] phase_t;

    // Number of phase MSBs the sine-address decode looks at: the wider of the
    // full-wave address and the quadrant bits plus the quarter-wave address.
    function automatic int sine_decode_w(input int lut_w, input int qlut_w);
        return (lut_w > qlut_w + 2) ? lut_w : qlut_w + 2;
    endfunction

endpackage

// File: rtl/phase_to_sine_addr.sv
// Combinational decode of the top phase bits into wavetable addressing:
// full-wave address, quadrant, mirrored quarter-wave address and negate flag.
module phase_to_sine_addr
    import phase_accumulator_pkg::*;
#(
    parameter int LUT_ADDR_W  = LUT_ADDR_W_DEFAULT,
    parameter int QLUT_ADDR_W = QLUT_ADDR_W_DEFAULT,
    localparam int DEC_W      = sine_decode_w(LUT_ADDR_W, QLUT_ADDR_W)
) (
    input  logic [DEC_W-1:0]       phase_msbs,
    output logic [LUT_ADDR_W-1:0]  lut_addr,
    output logic [1:0]             quadrant,
    output logic [QLUT_ADDR_W-1:0] qlut_addr,
    output logic                   negate
);

    logic [QLUT_ADDR_W-1:0] q;

    assign lut_addr = phase_msbs[DEC_W-1 -: LUT_ADDR_W];
    assign quadrant = phase_msbs[DEC_W-1 -: 2];
    assign q        = phase_msbs[DEC_W-3 -: QLUT_ADDR_W];
    assign negate   = quadrant[1];

    // Odd quadrants walk the quarter-wave table backwards: invert every bit.
    genvar gi;
    generate
        for (gi = 0; gi < QLUT_ADDR_W; gi++) begin : g_mirror
            assign qlut_addr[gi] = q[gi] ^ quadrant[0];
        end
    endgenerate

endmodule

// File: rtl/phase_accumulator.sv
// NCO phase core: wrapping phase register advanced by phase_step every clock,
// with a registered overflow pulse and wavetable address decode.
module phase_accumulator
    import phase_accumulator_pkg::*;
#(
    parameter int PHASE_W     = PHASE_W_DEFAULT,
    parameter int LUT_ADDR_W  = LUT_ADDR_W_DEFAULT,
    parameter int QLUT_ADDR_W = QLUT_ADDR_W_DEFAULT
) (
    input  logic                   clk,
    input  logic [PHASE_W-1:0]     phase_step,
    input  logic                   reset,
    output logic [PHASE_W-1:0]     phase,
    output logic                   wrap,
    output logic [LUT_ADDR_W-1:0]  lut_addr,
    output logic [1:0]             quadrant,
    output logic [QLUT_ADDR_W-1:0] qlut_addr,
    output logic                   negate
);

    localparam int DEC_W = sine_decode_w(LUT_ADDR_W, QLUT_ADDR_W);

    logic [PHASE_W-1:0] phase_reg;
    logic [PHASE_W-1:0] phase_next;
    logic               wrap_reg;
    logic               carry;

    // One extra bit on the sum captures the overflow past 2^PHASE_W.
    assign {carry, phase_next} = {1'b0, phase_reg} + {1'b0, phase_step};

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            phase_reg <= phase_next;
            wrap_reg  <= carry;
        end
    end

    assign phase = phase_reg;
    assign wrap  = wrap_reg;

    phase_to_sine_addr #(
        .LUT_ADDR_W  (LUT_ADDR_W),
        .QLUT_ADDR_W (QLUT_ADDR_W)
    ) u_decode (
        .phase_msbs (phase_reg[PHASE_W-1 -: DEC_W]),
        .lut_addr   (lut_addr),
        .quadrant   (quadrant),
        .qlut_addr  (qlut_addr),
        .negate     (negate)
    );

endmodule

// File: tb/tb_phase_accumulator.sv
// Self-checking bench for phase_accumulator: arithmetic reference model checked
// every cycle, directed literal checks, then randomized steps and resets.
module tb_phase_accumulator;

    logic        clk = 1'b0;
    logic [31:0] phase_step;
    logic        reset;
    logic [31:0] phase;
    logic        wrap;
    logic [9:0]  lut_addr;
    logic [1:0]  quadrant;
    logic [7:0]  qlut_addr;
    logic        negate;

    int tests_run = 0;
    int tests_failed = 0;

    phase_accumulator dut (
        .clk        (clk),
        .phase_step (phase_step),
        .reset      (reset),
        .phase      (phase),
        .wrap       (wrap),
        .lut_addr   (lut_addr),
        .quadrant   (quadrant),
        .qlut_addr  (qlut_addr),
        .negate     (negate)
    );

    always #5 clk = ~clk;

    // Reference model: phase as an integer modulo 2^32, wrap when the sum overflows.
    longint unsigned m_phase = 0;
    bit              m_wrap  = 1'b0;
    bit              m_valid = 1'b0;

    always @(posedge clk) begin
        longint unsigned sum;
        if (reset === 1'b0) begin
            m_phase = 0;
            m_wrap  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            sum     = m_phase + longint'(phase_step);
            m_wrap  = (sum >= 64'h1_0000_0000);
            m_phase = sum % 64'h1_0000_0000;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every cycle: compare all outputs against values derived from the model phase.
    always @(negedge clk) begin
        longint unsigned e_quad, e_q, e_qlut;
        if (m_valid) begin
            e_quad = m_phase / 64'h4000_0000;
            e_q    = (m_phase / 64'h40_0000) % 256;
            e_qlut = (e_quad % 2 == 1) ? 255 - e_q : e_q;
            check("model_phase",    64'(phase),     m_phase);
            check("model_wrap",     64'(wrap),      64'(m_wrap));
            check("model_lut_addr", 64'(lut_addr),  m_phase / 64'h40_0000);
            check("model_quadrant", 64'(quadrant),  e_quad);
            check("model_qlut",     64'(qlut_addr), e_qlut);
            check("model_negate",   64'(negate),    64'(e_quad >= 2));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] held;
    logic [31:0] quad_phase [4] = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0};
    logic [1:0]  quad_exp   [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0]  qlut_exp   [4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    logic [9:0]  lut_exp    [4] = '{10'h100, 10'h200, 10'h300, 10'h000};

    initial begin
        reset      = 1'b0;
        phase_step = 32'd100000;
        edges(2);
        $display("[TB] reset: phase=%0h wrap=%0b", phase, wrap);
        check("reset_phase",    64'(phase),     0);
        check("reset_wrap",     64'(wrap),      0);
        check("reset_lut",      64'(lut_addr),  0);
        check("reset_quadrant", 64'(quadrant),  0);
        check("reset_qlut",     64'(qlut_addr), 0);
        check("reset_negate",   64'(negate),    0);

        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            check("accum_wrap", 64'(wrap), 0);
        end
        $display("[TB] accumulate: phase=%0d", phase);
        check("accum_phase", 64'(phase), 1000000);

        reset = 1'b0;
        edges(1);
        reset      = 1'b1;
        phase_step = 32'h8000_0000;
        edges(1);
        $display("[TB] wrap step1: phase=%0h wrap=%0b", phase, wrap);
        check("wrap_phase1",  64'(phase),  64'h8000_0000);
        check("wrap_wrap1",   64'(wrap),   0);
        check("wrap_negate1", 64'(negate), 1);
        edges(1);
        $display("[TB] wrap step2: phase=%0h wrap=%0b", phase, wrap);
        check("wrap_phase2", 64'(phase), 0);
        check("wrap_wrap2",  64'(wrap),  1);
        edges(1);
        check("wrap_wrap3",  64'(wrap),  0);

        phase_step = 32'h1000;
        edges(3);
        check("step_phase", 64'(phase), 64'h8000_3000);
        phase_step = 32'h0;
        held = phase;
        for (int i = 0; i < 5; i++) begin
            edges(1);
            check("zero_hold", 64'(phase), 64'(held));
            check("zero_wrap", 64'(wrap),  0);
        end
        $display("[TB] zero step: phase=%0h", phase);
        phase_step = 32'hFFFF_FFFF;
        for (int i = 1; i <= 3; i++) begin
            edges(1);
            check("dec_phase", 64'(phase), 64'h8000_3000 - 64'(i));
            check("dec_wrap",  64'(wrap),  1);
        end
        $display("[TB] decrement: phase=%0h", phase);

        reset = 1'b0;
        edges(1);
        reset      = 1'b1;
        phase_step = 32'h4000_0000;
        for (int i = 0; i < 4; i++) begin
            edges(1);
            $display("[TB] quadrant: phase=%0h quad=%0d qlut=%0h lut=%0h", phase, quadrant, qlut_addr, lut_addr);
            check("quad_phase", 64'(phase),     64'(quad_phase[i]));
            check("quad_quad",  64'(quadrant),  64'(quad_exp[i]));
            check("quad_qlut",  64'(qlut_addr), 64'(qlut_exp[i]));
            check("quad_lut",   64'(lut_addr),  64'(lut_exp[i]));
        end

        reset = 1'b0;
        edges(1);
        reset      = 1'b1;
        phase_step = 32'h1234_0000;
        edges(1);
        check("mid_pre", 64'(phase), 64'h1234_0000);
        reset = 1'b0;
        edges(1);
        check("mid_reset", 64'(phase), 0);
        reset = 1'b1;
        edges(1);
        $display("[TB] reset mid-run restart: phase=%0h", phase);
        check("mid_restart", 64'(phase), 64'h1234_0000);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       phase_step = 32'($urandom_range(0, 1000));
                1:       phase_step = $urandom;
                2:       phase_step = 32'h0;
                default: phase_step = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            endcase
            reset = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
            edges(1);
        end
        $display("[TB] random: 400 cycles, final phase=%0h", phase);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
